// File: rtl/tx_interleave_sched_pkg.sv
// tx_pkg: constants, bank-state type and the BPSK first-permutation
// address shared by the coded-bit symbol scheduler.
package tx_pkg;

    localparam int N_COL       = 16;
    localparam int N_DBPS      = 24;
    // Rate-1/2 coding doubles the data bits of a BPSK symbol
    localparam int N_CBPS_BPSK = 2 * N_DBPS;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        FULL,
        DRAINING
    } bankState_t;

    // Coded bit k lands at row (k / N_COL) of column (k mod N_COL)
    function automatic int unsigned perm_addr(input int unsigned k, input int unsigned n_cbps);
        return (n_cbps / N_COL) * (k % N_COL) + (k / N_COL);
    endfunction

endpackage

// File: rtl/tx_interleave_sched_if.sv
// tx_interleave_sched_if: encoder-side write handshake, downstream read
// handshake and status lines of the symbol scheduler.
interface tx_interleave_sched_if;

    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic flush;
    logic out_valid;
    logic out_bit;
    logic out_ready;
    logic busy;
    logic sym_done;

    modport master (
        output in_valid, in_bit, flush, out_ready,
        input  in_ready, out_valid, out_bit, busy, sym_done
    );

    modport slave (
        input  in_valid, in_bit, flush, out_ready,
        output in_ready, out_valid, out_bit, busy, sym_done
    );

endinterface

// File: rtl/tx_interleave_sched_sym.sv
// tx_sym_bank: two banks of N_CBPS coded bits, one write port, one read
// port whose output register is the scheduler's out_bit.
module tx_sym_bank #(
    parameter int N_CBPS = 48,
    parameter int AW     = $clog2(N_CBPS)
) (
    input  logic          Clock2,
    input  logic          Reset,
    input  logic          clear_i,
    input  logic          wrEn_i,
    input  logic          wrBank_i,
    input  logic [AW-1:0] wrAddr_i,
    input  logic          wrBit_i,
    input  logic          rdEn_i,
    input  logic          rdBank_i,
    input  logic [AW-1:0] rdAddr_i,
    output logic          rdBit_o
);

    logic [N_CBPS-1:0] mem_q [2];
    logic              rdBit_q;

    // Plain storage: every address is rewritten before a bank is ever read
    always_ff @(posedge Clock2) begin
        if (wrEn_i) begin
            mem_q[wrBank_i][wrAddr_i] <= wrBit_i;
        end
    end

    // Registered read; the register holds while the consumer stalls
    always_ff @(posedge Clock2 or posedge Reset) begin
        if (Reset) begin
            rdBit_q <= 1'b0;
        end else if (clear_i) begin
            rdBit_q <= 1'b0;
        end else if (rdEn_i) begin
            rdBit_q <= mem_q[rdBank_i][rdAddr_i];
        end
    end

    assign rdBit_o = rdBit_q;

endmodule

// File: rtl/tx_interleave_sched.sv
// tx_interleave_sched: ping-pong coded-bit symbol scheduler. Bits are written
// at permuted addresses into one bank while the other drains in order.
// Build macro TX_INTERLEAVE_PAD_FLUSH_EN: flush of a partial bank zero-pads
// it to a full symbol instead of discarding it.
module tx_interleave_sched
    import tx_pkg::*;
#(
    parameter int N_CBPS = N_CBPS_BPSK,
    parameter int AW     = $clog2(N_CBPS)
) (
    input  logic                 Clock2,
    input  logic                 Reset,
    input  logic                 Clear,
    tx_interleave_sched_if.slave bus
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_CBPS - 1);

    bankState_t    bankState_q [2];
    bankState_t    bankState_d [2];
    logic          wrBank_q, wrBank_d;
    logic          rdBank_q, rdBank_d;
    logic [AW-1:0] wrCnt_q, wrCnt_d;
    logic [AW-1:0] rdCnt_q, rdCnt_d;
    logic          outValid_q, outValid_d;
    logic          readyEn_q;
    logic          padding;
    logic          inReady, wrEn, wrBit, rdAccept, rdLast, rdEn, rdBankSel;
    logic [AW-1:0] wrAddr, rdAddr;

`ifdef TX_INTERLEAVE_PAD_FLUSH_EN
    logic padActive_q, padActive_d;
    assign padding = padActive_q;
`else
    assign padding = 1'b0;
`endif

    assign wrAddr   = AW'(perm_addr({{(32-AW){1'b0}}, wrCnt_q}, unsigned'(N_CBPS)));
    assign inReady  = readyEn_q && !padding &&
                      (bankState_q[wrBank_q] == FREE || bankState_q[wrBank_q] == FILLING);
    assign wrEn     = (bus.in_valid && inReady) || padding;
    assign wrBit    = bus.in_bit && !padding;
    assign rdAccept = outValid_q && bus.out_ready;
    assign rdLast   = rdAccept && (rdCnt_q == LAST_IDX);

    // Next state for both banks: write side and read side never touch the same bank
    always_comb begin
        bankState_d[0] = bankState_q[0];
        bankState_d[1] = bankState_q[1];
        wrBank_d       = wrBank_q;
        wrCnt_d        = wrCnt_q;
        rdBank_d       = rdBank_q;
        rdCnt_d        = rdCnt_q;
        outValid_d     = outValid_q;
        rdEn           = 1'b0;
        rdBankSel      = rdBank_q;
        rdAddr         = rdCnt_q;
`ifdef TX_INTERLEAVE_PAD_FLUSH_EN
        padActive_d    = padActive_q;
`endif

        if (wrEn) begin
            if (wrCnt_q == LAST_IDX) begin
                wrCnt_d                 = '0;
                bankState_d[wrBank_q]   = FULL;
                wrBank_d                = ~wrBank_q;
`ifdef TX_INTERLEAVE_PAD_FLUSH_EN
                padActive_d             = 1'b0;
`endif
            end else begin
                wrCnt_d                 = wrCnt_q + 1'b1;
                bankState_d[wrBank_q]   = FILLING;
            end
        end

        if (bus.flush && !padding && (wrCnt_d != '0)) begin
`ifdef TX_INTERLEAVE_PAD_FLUSH_EN
            padActive_d = 1'b1;
`else
            bankState_d[wrBank_q] = FREE;
            wrCnt_d               = '0;
`endif
        end

        if (!outValid_q) begin
            if (bankState_q[rdBank_q] == FULL) begin
                rdEn       = 1'b1;
                outValid_d = 1'b1;
            end
        end else if (rdAccept) begin
            if (rdLast) begin
                bankState_d[rdBank_q] = FREE;
                rdBank_d              = ~rdBank_q;
                rdCnt_d               = '0;
                outValid_d            = 1'b0;
                if (bankState_q[~rdBank_q] == FULL) begin
                    rdEn       = 1'b1;
                    rdBankSel  = ~rdBank_q;
                    rdAddr     = '0;
                    outValid_d = 1'b1;
                end
            end else begin
                if (rdCnt_q == '0) begin
                    bankState_d[rdBank_q] = DRAINING;
                end
                rdCnt_d = rdCnt_q + 1'b1;
                rdAddr  = rdCnt_q + 1'b1;
                rdEn    = 1'b1;
            end
        end
    end

    // Scheduler registers; Clear discards everything but keeps the write side open
    always_ff @(posedge Clock2 or posedge Reset) begin
        if (Reset) begin
            bankState_q[0] <= FREE;
            bankState_q[1] <= FREE;
            wrBank_q       <= 1'b0;
            rdBank_q       <= 1'b0;
            wrCnt_q        <= '0;
            rdCnt_q        <= '0;
            outValid_q     <= 1'b0;
            readyEn_q      <= 1'b0;
        end else if (Clear) begin
            bankState_q[0] <= FREE;
            bankState_q[1] <= FREE;
            wrBank_q       <= 1'b0;
            rdBank_q       <= 1'b0;
            wrCnt_q        <= '0;
            rdCnt_q        <= '0;
            outValid_q     <= 1'b0;
            readyEn_q      <= 1'b1;
        end else begin
            bankState_q[0] <= bankState_d[0];
            bankState_q[1] <= bankState_d[1];
            wrBank_q       <= wrBank_d;
            rdBank_q       <= rdBank_d;
            wrCnt_q        <= wrCnt_d;
            rdCnt_q        <= rdCnt_d;
            outValid_q     <= outValid_d;
            readyEn_q      <= 1'b1;
        end
    end

`ifdef TX_INTERLEAVE_PAD_FLUSH_EN
    // Pad sub-state flag, cleared once the padded bank wraps to FULL
    always_ff @(posedge Clock2 or posedge Reset) begin
        if (Reset) begin
            padActive_q <= 1'b0;
        end else if (Clear) begin
            padActive_q <= 1'b0;
        end else begin
            padActive_q <= padActive_d;
        end
    end
`endif

    tx_sym_bank #(
        .N_CBPS (N_CBPS),
        .AW     (AW)
    ) uBank (
        .Clock2   (Clock2),
        .Reset    (Reset),
        .clear_i  (Clear),
        .wrEn_i   (wrEn),
        .wrBank_i (wrBank_q),
        .wrAddr_i (wrAddr),
        .wrBit_i  (wrBit),
        .rdEn_i   (rdEn),
        .rdBank_i (rdBankSel),
        .rdAddr_i (rdAddr),
        .rdBit_o  (bus.out_bit)
    );

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.sym_done  = rdLast && !Clear;
    assign bus.busy      = (bankState_q[0] != FREE) || (bankState_q[1] != FREE) || outValid_q;

endmodule

// File: tb/tb_tx_interleave_sched.sv
// tb_tx_interleave_sched: randomized scoreboard bench for the coded-bit
// symbol scheduler. Honours TX_INTERLEAVE_PAD_FLUSH_EN like the design.
module tb_tx_interleave_sched;

    localparam int NCB  = 48;
    localparam int ROWS = NCB / 16;

    typedef struct {
        bit b;
        bit last;
    } exp_t;

    logic Clock2;
    logic Reset;
    logic Clear;
    tx_interleave_sched_if bus();

    exp_t expQ[$];
    bit   curSym[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;
    int   outCount = 0;

    tx_interleave_sched dut (
        .Clock2 (Clock2),
        .Reset  (Reset),
        .Clear  (Clear),
        .bus    (bus)
    );

    // Coded-bit clock
    initial Clock2 = 1'b0;
    always #5 Clock2 = ~Clock2;

    // Hard stop if the sequence ever wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: coded bit k appears at read index ROWS*(k mod 16) + k/16
    task automatic finishSym();
        bit   outArr[NCB];
        exp_t x;
        for (int k = 0; k < NCB; k++) outArr[ROWS * (k % 16) + k / 16] = curSym[k];
        for (int i = 0; i < NCB; i++) begin
            x.b    = outArr[i];
            x.last = (i == NCB - 1);
            expQ.push_back(x);
        end
        curSym.delete();
    endtask

    // Monitor: compares presented outputs, and feeds the model with accepted inputs
    always @(negedge Clock2) begin
        if (Reset) begin
            expQ.delete();
            curSym.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedOutput", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outBit", bus.out_bit, e.b);
                    checkOutput("symDone", bus.sym_done, e.last);
                end
                outCount++;
            end else begin
                checkOutput("symDoneIdle", bus.sym_done, 0);
            end
            if (bus.in_valid && bus.in_ready) begin
                curSym.push_back(bus.in_bit);
                if (curSym.size() == NCB) finishSym();
            end
            if (bus.flush && curSym.size() > 0) begin
`ifdef TX_INTERLEAVE_PAD_FLUSH_EN
                while (curSym.size() < NCB) curSym.push_back(1'b0);
                finishSym();
`else
                curSym.delete();
`endif
            end
            if (Clear) begin
                expQ.delete();
                curSym.delete();
            end
        end
    end

    // Offer one bit at posedge+1 and hold it until the write is accepted
    task automatic applyStimulus(input bit b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(negedge Clock2);
        while (!bus.in_ready && n < 500) begin
            n++;
            @(negedge Clock2);
        end
        if (!bus.in_ready) checkOutput("writeTimeout", 0, 1);
        @(posedge Clock2);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge Clock2);
        while ((bus.busy || expQ.size() != 0) && n < 2000) begin
            n++;
            @(negedge Clock2);
        end
        checkOutput("idleReached", bus.busy, 0);
        checkOutput("expectedDrained", expQ.size(), 0);
        @(posedge Clock2);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "InReady"}, bus.in_ready, 0);
        checkOutput({tag, "OutValid"}, bus.out_valid, 0);
        checkOutput({tag, "OutBit"}, bus.out_bit, 0);
        checkOutput({tag, "Busy"}, bus.busy, 0);
        checkOutput({tag, "SymDone"}, bus.sym_done, 0);
    endtask

    initial begin
        int n;
        int gaps;
        int base;
        Reset         = 1'b1;
        Clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkResetOutputs("reset");

        // Release reset mid-cycle: write side opens after the first edge
        #21;
        Reset = 1'b0;
        #1;
        checkOutput("readyBeforeFirstEdge", bus.in_ready, 0);
        @(posedge Clock2);
        #1;
        checkOutput("readyAfterFirstEdge", bus.in_ready, 1);

        // Single one at k=1 must surface at read index 3
        for (int k = 0; k < NCB; k++) applyStimulus(k == 1);
        checkOutput("validNotYet", bus.out_valid, 0);
        @(posedge Clock2);
        #1;
        checkOutput("validOneCycleAfterFull", bus.out_valid, 1);
        checkOutput("busyWhileDraining", bus.busy, 1);
        waitIdle();

        // Three back-to-back symbols: symbols 0 and 1 must drain without a bubble
        base = outCount;
        fork
            begin
                for (int k = 0; k < 3 * NCB; k++) applyStimulus(1'($urandom % 2));
            end
            begin
                n    = 0;
                gaps = 0;
                @(negedge Clock2);
                while (!bus.out_valid && n < 300) begin
                    n++;
                    @(negedge Clock2);
                end
                checkOutput("firstOutputSeen", bus.out_valid, 1);
                for (int c = 0; c < 2 * NCB - 1; c++) begin
                    @(negedge Clock2);
                    if (!bus.out_valid) gaps++;
                end
                checkOutput("noGapSym0to1", gaps, 0);
            end
        join
        waitIdle();
        checkOutput("streamOutputs", outCount - base, 3 * NCB);

        // Random input gaps and random downstream stalls over four symbols
        base = outCount;
        fork
            begin
                for (int k = 0; k < 4 * NCB; k++) begin
                    if ($urandom % 3 == 0) begin
                        @(posedge Clock2);
                        #1;
                    end
                    applyStimulus(1'($urandom % 2));
                end
            end
            begin
                for (int c = 0; c < 600; c++) begin
                    @(posedge Clock2);
                    #1;
                    bus.out_ready = ($urandom % 4) != 0;
                end
                bus.out_ready = 1'b1;
            end
        join
        waitIdle();
        checkOutput("randomOutputs", outCount - base, 4 * NCB);

        // Both banks full: the 97th bit stalls until bank 0 frees
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2 * NCB; k++) applyStimulus(1'($urandom % 2));
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'($urandom % 2);
        @(negedge Clock2);
        checkOutput("readyLowBothFull", bus.in_ready, 0);
        @(posedge Clock2);
        #1;
        bus.out_ready = 1'b1;
        n = 0;
        @(negedge Clock2);
        while (!bus.sym_done && n < 200) begin
            n++;
            @(negedge Clock2);
        end
        checkOutput("firstSymDoneSeen", bus.sym_done, 1);
        checkOutput("readyLowOnFreeCycle", bus.in_ready, 0);
        @(negedge Clock2);
        checkOutput("readyAfterBankFree", bus.in_ready, 1);
        @(posedge Clock2);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k < NCB; k++) applyStimulus(1'($urandom % 2));
        waitIdle();

        // Flush with nothing written is a no-op
        bus.flush = 1'b1;
        @(posedge Clock2);
        #1;
        bus.flush = 1'b0;
        checkOutput("emptyFlushBusy", bus.busy, 0);
        checkOutput("emptyFlushReady", bus.in_ready, 1);

        // Twenty ones then flush
        base = outCount;
        for (int k = 0; k < 20; k++) applyStimulus(1'b1);
        bus.flush = 1'b1;
        @(posedge Clock2);
        #1;
        bus.flush = 1'b0;
`ifdef TX_INTERLEAVE_PAD_FLUSH_EN
        n = 0;
        @(negedge Clock2);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge Clock2);
        end
        checkOutput("padCycles", n, NCB - 20);
        @(posedge Clock2);
        #1;
        waitIdle();
        checkOutput("paddedOutputs", outCount - base, NCB);
`else
        checkOutput("discardBusy", bus.busy, 0);
        repeat (60) @(posedge Clock2);
        #1;
        checkOutput("discardNoOutput", outCount - base, 0);
        checkOutput("discardReady", bus.in_ready, 1);
`endif

        // Clear in the middle of a drain
        base = outCount;
        for (int k = 0; k < NCB; k++) applyStimulus(1'($urandom % 2));
        n = 0;
        while (outCount < base + 10 && n < 300) begin
            n++;
            @(negedge Clock2);
        end
        checkOutput("reachedOutput10", outCount - base, 10);
        @(posedge Clock2);
        #1;
        Clear = 1'b1;
        @(posedge Clock2);
        #1;
        Clear = 1'b0;
        checkOutput("clearOutValid", bus.out_valid, 0);
        checkOutput("clearBusy", bus.busy, 0);
        checkOutput("clearSymDone", bus.sym_done, 0);
        checkOutput("clearReady", bus.in_ready, 1);
        for (int k = 0; k < NCB; k++) applyStimulus(1'($urandom % 2));
        waitIdle();

        // Asynchronous reset mid-fill
        for (int k = 0; k < 20; k++) applyStimulus(1'($urandom % 2));
        checkOutput("busyMidFill", bus.busy, 1);
        #2;
        Reset = 1'b1;
        #1;
        checkResetOutputs("asyncReset");
        @(negedge Clock2);
        #1;
        Reset = 1'b0;
        #1;
        checkOutput("readyLowAfterDeassert", bus.in_ready, 0);
        @(posedge Clock2);
        #1;
        checkOutput("readyHighForSecondEdge", bus.in_ready, 1);
        base = outCount;
        for (int k = 0; k < NCB; k++) applyStimulus(1'($urandom % 2));
        waitIdle();
        checkOutput("postResetOutputs", outCount - base, NCB);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
